req_encoder: RTL and testbench

REQ_ENCODER -- requirements
Module: req_encoder

---
 rtl/enc_pkg.sv | 12 +
 rtl/prio_enc.sv | 24 ++
 rtl/req_encoder.sv | 93 +++++++++
 tb/tb_req_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder: FSM state encoding and the
// default number of request lines.
package enc_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam int N_DEFAULT = 4;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: returns the index of the lowest set bit
// of vec and a flag telling whether any bit is set.
module prio_enc #(
   parameter int N = 4,
   localparam int CW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [CW-1:0] idx,
   output logic          any
);

   // Scan from the top down so the lowest set bit is the last assignment.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = CW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_encoder.sv
// Collects single-cycle request pulses into a pending set and presents them
// one at a time as binary codes over a valid/ready handshake, lowest index first.
module req_encoder
   import enc_pkg::*;
#(
   parameter int N = N_DEFAULT,
   localparam int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_in,
   output logic [CW-1:0] code_out,
   output logic          code_valid,
   input  logic          code_ready,
   output logic [N-1:0]  pending,
   output logic          overflow
);

   generate
      if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
         $error("req_encoder: N must be a power of two and at least 2");
      end
   endgenerate

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] enc_idx;
   logic          enc_any;
   logic          hs;
   logic          load;
   logic [N-1:0]  grant;
   logic [N-1:0]  pending_nxt;
   logic          overflow_nxt;

   // Only the registered pending set feeds the encoder; req_in never bypasses it.
   prio_enc #(
      .N (N)
   ) u_prio_enc (
      .vec (pending),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign hs   = code_valid & code_ready;
   assign load = enc_any & ((state == IDLE) | hs);

   always_comb begin
      grant = '0;
      if (load) begin
         grant = {{(N-1){1'b0}}, 1'b1} << enc_idx;
      end
   end

   // A new request on a bit being granted in the same cycle keeps it pending.
   assign pending_nxt  = (pending & ~grant) | req_in;
   assign overflow_nxt = |(req_in & pending & ~grant);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (enc_any) begin
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (hs && !enc_any) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         code_out   <= '0;
         code_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pending    <= pending_nxt;
         overflow   <= overflow_nxt;
         code_valid <= (state_nxt == PRESENT);
         if (load) begin
            code_out <= enc_idx;
         end
      end
   end

endmodule

// File: tb/tb_req_encoder.sv
// Scoreboard bench for req_encoder: stimulus pushes expected codes, a monitor
// pops and compares on every accepted handshake.
module tb_req_encoder;

   logic       clk;
   logic       rst_n;
   logic [3:0] req_in;
   logic [1:0] code_out;
   logic       code_valid;
   logic       code_ready;
   logic [3:0] pending;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   req_encoder #(.N(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_in     (req_in),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .pending    (pending),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted code must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && code_valid && code_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_code: got %0d expected none", code_out);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(code_out) != e) begin
               bad++;
               $display("FAIL code_order: got %0d expected %0d", code_out, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      req_in     = '0;
      code_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", code_valid, 0);
      chk("rst_code", code_out, 0);
      chk("rst_pending", pending, 0);
      chk("rst_overflow", overflow, 0);
      step();
      rst_n = 1'b1;

      // Single request, two-cycle latency
      req_in = 4'b0100; code_ready = 1'b1; exp_q.push_back(2);
      step(); req_in = '0;
      @(negedge clk);
      chk("single_pend", pending, 4'b0100);
      chk("single_valid_early", code_valid, 0);
      step();
      @(negedge clk);
      chk("single_valid", code_valid, 1);
      chk("single_code", code_out, 2);
      chk("single_pend_clr", pending, 0);
      step();
      @(negedge clk);
      chk("single_idle", code_valid, 0);
      chk("single_hold_code", code_out, 2);
      step(); step();

      // Simultaneous requests, back-to-back presentation
      req_in = 4'b1011; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      step(); req_in = '0;
      @(negedge clk);
      chk("multi_pend", pending, 4'b1011);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         chk("multi_valid", code_valid, 1);
      end
      step();
      @(negedge clk);
      chk("multi_idle", code_valid, 0);
      chk("multi_pend_clr", pending, 0);
      step();

      // Backpressure holds the code stable
      code_ready = 1'b0; req_in = 4'b0010; exp_q.push_back(1);
      step(); req_in = '0;
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", code_valid, 1);
         chk("bp_code", code_out, 1);
         step();
      end
      code_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_done", code_valid, 0);
      step();

      // Overflow on an already-pending, blocked bit
      code_ready = 1'b0; req_in = 4'b1001; exp_q.push_back(0); exp_q.push_back(3);
      step(); req_in = '0;
      step(); req_in = 4'b1000;
      step(); req_in = '0;
      @(negedge clk);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_pend", pending, 4'b1000);
      chk("ovf_code", code_out, 0);
      step();
      @(negedge clk);
      chk("ovf_clear", overflow, 0);
      step();
      code_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("ovf_idle", code_valid, 0);
      chk("ovf_pend_clr", pending, 0);

      // Set wins over grant on the same bit
      code_ready = 1'b0; req_in = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
      step(); req_in = 4'b0001;
      step(); req_in = '0;
      @(negedge clk);
      chk("coll_pend", pending, 4'b0011);
      chk("coll_no_ovf", overflow, 0);
      chk("coll_valid", code_valid, 1);
      chk("coll_code", code_out, 0);
      step();
      code_ready = 1'b1;
      repeat (4) step();
      @(negedge clk);
      chk("coll_idle", code_valid, 0);
      chk("coll_pend_clr", pending, 0);

      // Reset mid-operation discards everything
      step();
      code_ready = 1'b0; req_in = 4'b1111;
      step(); req_in = '0;
      step();
      chk("pre_rst_pend", pending, 4'b1110);
      chk("pre_rst_valid", code_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", code_valid, 0);
      chk("arst_code", code_out, 0);
      chk("arst_pend", pending, 0);
      chk("arst_ovf", overflow, 0);
      step();
      rst_n = 1'b1; code_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         chk("post_rst_quiet", code_valid, 0);
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
